// File: rtl/comp_host_ctrl.sv
// Host-side session controller for the comp core: image load, core reset, run capture, drain.
// Latency: oob write 1 cycle after each src handshake; drain_valid registered, first word 1 cycle into DRAIN.
// Backpressure: src_ready only in LOAD; drain word is held stable while drain_valid && !drain_ready.
module comp_host_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int CAP_DEPTH  = 32,
  parameter int RST_CYCLES = 1,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH:0]            load_count,
  input  logic [DATA_WIDTH-1:0]          src_data,
  input  logic                           src_valid,
  output logic                           src_ready,
  output logic                           oob_wen,
  output logic [ADDR_WIDTH-1:0]          oob_wr_addr,
  output logic [DATA_WIDTH-1:0]          oob_wr_data,
  output logic                           core_rst,
  input  logic [DATA_WIDTH-1:0]          core_out,
  input  logic                           core_outen,
  input  logic                           core_halt,
  output logic [DATA_WIDTH-1:0]          drain_data,
  output logic                           drain_valid,
  input  logic                           drain_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic                           overflow,
  output logic [$clog2(CAP_DEPTH+1)-1:0] out_count
);

  localparam int CW  = $clog2(CAP_DEPTH + 1);
  localparam int IW  = (CAP_DEPTH > 1) ? $clog2(CAP_DEPTH) : 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int MCW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [ADDR_WIDTH:0] IMG_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [RCW-1:0]      RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [MCW-1:0]      CYC_LAST = MCW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0]       CAP_FULL = CW'(CAP_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_RESET_CORE = 3'd2,
    S_RUN        = 3'd3,
    S_DRAIN      = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     wcnt_q, wcnt_d;
  logic [ADDR_WIDTH:0]     target_q, target_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [RCW-1:0]          rcnt_q, rcnt_d;
  logic [MCW-1:0]          cyc_q, cyc_d;
  logic [CW-1:0]           ocnt_q, ocnt_d;
  logic [CW-1:0]           rd_idx_q, rd_idx_d;
  logic                    dv_q, dv_d;
  logic [DATA_WIDTH-1:0]   ddata_q, ddata_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic                    overflow_q, overflow_d;
  logic                    cap_we;

  logic [DATA_WIDTH-1:0]   mem_q [CAP_DEPTH];

  // The image is fully accepted once the word counter reaches the clamped target;
  // that cycle lets the last registered oob write land before the core reset phase.
  logic load_full;
  assign load_full = (wcnt_q == target_q);

  assign src_ready   = (state_q == S_LOAD) && !load_full;
  assign oob_wen     = wen_q;
  assign oob_wr_addr = waddr_q;
  assign oob_wr_data = wdata_q;
  assign core_rst    = (state_q != S_RUN);
  assign drain_data  = ddata_q;
  assign drain_valid = dv_q;
  assign busy        = (state_q == S_LOAD) || (state_q == S_RESET_CORE) ||
                       (state_q == S_RUN)  || (state_q == S_DRAIN);
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign out_count   = ocnt_q;

  // Next-state and datapath updates for the whole session sequence.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    target_d   = target_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    rcnt_d     = rcnt_q;
    cyc_d      = cyc_q;
    ocnt_d     = ocnt_q;
    rd_idx_d   = rd_idx_q;
    dv_d       = dv_q;
    ddata_d    = ddata_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    cap_we     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
          ocnt_d     = '0;
          wcnt_d     = '0;
          rcnt_d     = '0;
          target_d   = (load_count > IMG_MAX) ? IMG_MAX : load_count;
          state_d    = (load_count != '0) ? S_LOAD : S_RESET_CORE;
        end
      end

      S_LOAD: begin
        if (load_full) begin
          rcnt_d  = '0;
          state_d = S_RESET_CORE;
        end else if (src_valid) begin
          wen_d   = 1'b1;
          waddr_d = wcnt_q[ADDR_WIDTH-1:0];
          wdata_d = src_data;
          wcnt_d  = wcnt_q + 1'b1;
        end
      end

      S_RESET_CORE: begin
        if (rcnt_q == RST_LAST) begin
          cyc_d   = '0;
          state_d = S_RUN;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end

      S_RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (core_outen) begin
          if (ocnt_q < CAP_FULL) begin
            cap_we = 1'b1;
            ocnt_d = ocnt_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        // Halt takes priority over the cycle limit when both land together.
        if (core_halt || (cyc_q == CYC_LAST)) begin
          timeout_d = !core_halt;
          rd_idx_d  = '0;
          dv_d      = 1'b0;
          if (ocnt_d == '0) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Output register refills only when empty or its word is being taken.
        if (!dv_q || drain_ready) begin
          if (rd_idx_q != ocnt_q) begin
            dv_d     = 1'b1;
            ddata_d  = mem_q[rd_idx_q[IW-1:0]];
            rd_idx_d = rd_idx_q + 1'b1;
          end else begin
            dv_d    = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Session state and counters; reset returns everything to an idle, core-held state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      target_q   <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rcnt_q     <= '0;
      cyc_q      <= '0;
      ocnt_q     <= '0;
      rd_idx_q   <= '0;
      dv_q       <= 1'b0;
      ddata_q    <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      target_q   <= target_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      rcnt_q     <= rcnt_d;
      cyc_q      <= cyc_d;
      ocnt_q     <= ocnt_d;
      rd_idx_q   <= rd_idx_d;
      dv_q       <= dv_d;
      ddata_q    <= ddata_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

  // Capture buffer storage; contents are only meaningful below out_count.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      mem_q[ocnt_q[IW-1:0]] <= core_out;
    end
  end

endmodule

// File: tb/tb_comp_host_ctrl.sv
module tb_comp_host_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 3;
  localparam int CAP  = 4;
  localparam int RSTC = 2;
  localparam int MAXC = 50;
  localparam int CW   = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   load_count;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic          oob_wen;
  logic [AW-1:0] oob_wr_addr;
  logic [DW-1:0] oob_wr_data;
  logic          core_rst;
  logic [DW-1:0] core_out;
  logic          core_outen;
  logic          core_halt;
  logic [DW-1:0] drain_data;
  logic          drain_valid;
  logic          drain_ready;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          overflow;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  comp_host_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAP_DEPTH(CAP),
    .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .load_count(load_count),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .oob_wen(oob_wen), .oob_wr_addr(oob_wr_addr), .oob_wr_data(oob_wr_data),
    .core_rst(core_rst), .core_out(core_out), .core_outen(core_outen),
    .core_halt(core_halt), .drain_data(drain_data), .drain_valid(drain_valid),
    .drain_ready(drain_ready), .busy(busy), .done(done), .timeout(timeout),
    .overflow(overflow), .out_count(out_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0]   exp_wr_q [$];
  logic [DW-1:0] exp_dr_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a session, stream words base+step*i, check every oob write against the queue.
  task automatic do_load(input logic [AW:0] lc, input int exp_n,
                         input logic [DW-1:0] base, input logic [DW-1:0] step);
    int sent, writes, last_wr, fall;
    bit consec, hs;
    logic [63:0] e;
    sent = 0; writes = 0; last_wr = -1; fall = -1; consec = 1'b1;
    exp_wr_q.delete();
    start = 1'b1; load_count = lc;
    tick;
    start = 1'b0;
    chk("start_clr_done", done, 0);
    chk("start_clr_cnt", out_count, 0);
    chk("start_clr_ovf", overflow, 0);
    chk("start_clr_tmo", timeout, 0);
    src_valid = 1'b1;
    src_data  = base;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (!core_rst) begin
        fall = cyc;
        break;
      end
      hs = src_ready && src_valid;
      if (hs) exp_wr_q.push_back({32'(sent), src_data});
      tick;
      if (hs) begin
        sent++;
        src_data = base + step * DW'(sent);
      end
      if (oob_wen) begin
        writes++;
        if (last_wr >= 0 && cyc + 1 != last_wr + 1) consec = 1'b0;
        last_wr = cyc + 1;
        if (exp_wr_q.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", oob_wr_addr, e[63:32]);
          chk("wr_data", oob_wr_data, e[31:0]);
        end
      end
    end
    src_valid = 1'b0;
    chk("load_bound", fall >= 0, 1);
    chk("wr_count", writes, exp_n);
    chk("wr_left", exp_wr_q.size(), 0);
    if (exp_n > 0) begin
      chk("rst_release_lat", fall - last_wr, RSTC + 1);
      chk("wr_consecutive", consec, 1);
    end else begin
      chk("rst_release_noload", fall, RSTC);
    end
    chk("wen_after_load", oob_wen, 0);
    chk("busy_run", busy, 1);
  endtask

  // Drive outen on cycles [out_start, out_start+n_out) with vbase+k, halt on halt_cyc.
  task automatic run_core(input int out_start, input int n_out, input int halt_cyc,
                          input logic [DW-1:0] vbase, output int run_cycles);
    int mcnt;
    mcnt = 0;
    run_cycles = -1;
    exp_dr_q.delete();
    for (int c = 0; c < MAXC + 20; c++) begin
      if (core_rst) begin
        run_cycles = c;
        break;
      end
      core_outen = (c >= out_start) && (c < out_start + n_out);
      core_out   = vbase + DW'(c - out_start);
      core_halt  = (c == halt_cyc);
      if (core_outen && mcnt < CAP) begin
        exp_dr_q.push_back(core_out);
        mcnt++;
      end
      tick;
    end
    core_outen = 1'b0;
    core_halt  = 1'b0;
    chk("run_bound", run_cycles >= 0, 1);
  endtask

  // Drain with a repeating 4-cycle ready pattern (MSB first); check holds during stalls.
  task automatic do_drain(input logic [3:0] pat);
    bit pv, pr, fin;
    logic [DW-1:0] pd, e;
    pv = 1'b0; pr = 1'b0; fin = 1'b0; pd = '0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        fin = 1'b1;
        break;
      end
      if (pv && !pr) begin
        chk("stall_valid", drain_valid, 1);
        chk("stall_hold", drain_data, pd);
      end
      drain_ready = pat[3 - (k % 4)];
      if (drain_valid && drain_ready) begin
        if (exp_dr_q.size() == 0) begin
          chk("drain_extra", 1, 0);
        end else begin
          e = exp_dr_q.pop_front();
          chk("drain_word", drain_data, e);
        end
      end
      pv = drain_valid; pr = drain_ready; pd = drain_data;
      tick;
    end
    drain_ready = 1'b0;
    chk("drain_bound", fin, 1);
    chk("drain_left", exp_dr_q.size(), 0);
    chk("done_busy", busy, 0);
    chk("done_core_rst", core_rst, 1);
  endtask

  initial begin
    int rc;
    rst = 1'b1; start = 1'b0; load_count = '0; src_data = '0; src_valid = 1'b0;
    core_out = '0; core_outen = 1'b0; core_halt = 1'b0; drain_ready = 1'b0;
    tick;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wen", oob_wen, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_drain_valid", drain_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_flags", {timeout, overflow}, 0);
    rst = 1'b0;
    tick;

    // Four-word load, then halt coinciding with the fourth outen; stalling drain.
    do_load(4'd4, 4, 32'h11, 32'h11);
    run_core(0, 4, 3, 32'hA, rc);
    chk("halt_run_len", rc, 4);
    chk("halt_out_count", out_count, 4);
    chk("halt_timeout", timeout, 0);
    chk("halt_overflow", overflow, 0);
    do_drain(4'b1001);
    chk("halt_done", done, 1);

    // Empty image, no halt: cycle-limit timeout with two captures.
    do_load(4'd0, 0, 32'h0, 32'h0);
    run_core(0, 2, -1, 32'h55, rc);
    chk("tmo_run_len", rc, MAXC);
    chk("tmo_flag", timeout, 1);
    chk("tmo_out_count", out_count, 2);
    do_drain(4'b1111);
    chk("tmo_done", done, 1);
    chk("tmo_hold", timeout, 1);

    // Oversized load_count clamps to the full image; halt on the last allowed cycle.
    do_load(4'd12, 8, 32'h100, 32'h1);
    run_core(MAXC - 1, 1, MAXC - 1, 32'h77, rc);
    chk("edge_run_len", rc, MAXC);
    chk("edge_timeout", timeout, 0);
    chk("edge_out_count", out_count, 1);
    do_drain(4'b1111);

    // Six outens into a four-entry buffer.
    do_load(4'd2, 2, 32'hC0DE, 32'h10);
    run_core(0, 6, 6, 32'h1, rc);
    chk("ovf_run_len", rc, 7);
    chk("ovf_out_count", out_count, CAP);
    chk("ovf_flag", overflow, 1);
    do_drain(4'b1111);
    chk("ovf_hold", overflow, 1);
    chk("ovf_cnt_hold", out_count, CAP);

    // Reset pulsed after two of four words, then a clean reload from address 0.
    start = 1'b1; load_count = 4'd4;
    tick;
    start = 1'b0; src_valid = 1'b1; src_data = 32'hDEAD;
    tick;
    src_data = 32'hBEEF;
    tick;
    src_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_core_rst", core_rst, 1);
    chk("midrst_wen", oob_wen, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_src_ready", src_ready, 0);
    tick;
    rst = 1'b0;
    tick;
    do_load(4'd4, 4, 32'h11, 32'h11);
    run_core(0, 0, 0, 32'h0, rc);
    chk("empty_run_len", rc, 1);
    chk("empty_out_count", out_count, 0);
    do_drain(4'b1111);
    chk("empty_done", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
